fetch_pc_unit: RTL and testbench

//  Fetch stage directly upstream of the combinational instruction memory. Owns
//  the PC, drives the word-addressed fetch address, and captures each returned

---
 rtl/fetch_pc_unit.sv | 132 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and buffers
// up to two {pc, instr} pairs for decode behind a valid/ready handshake.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        fault
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  count_q, count_d;
   logic        head_q, head_d;
   logic        fault_q, fault_d;
   logic [31:0] buf_pc_q  [2];
   logic [31:0] buf_ins_q [2];

   logic pop;
   logic fetch_req;
   logic push;
   logic tail;
   logic misaligned;
   logic out_of_range;

   assign pop          = (state_q == ST_RUN) && (count_q != 2'd0) && out_ready;
   assign fetch_req    = (count_q < 2'd2) || pop;
   assign tail         = head_q ^ count_q[0];
   assign misaligned   = (redirect_target[1:0] != 2'b00);
   assign out_of_range = ({1'b0, pc_q} >= PC_LIMIT);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      head_d  = head_q;
      fault_d = fault_q;
      push    = 1'b0;
      case (state_q)
         ST_INIT: begin
            state_d = ST_RUN;
            if (redirect_valid) begin
               if (misaligned) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
               end else begin
                  pc_d = redirect_target;
               end
            end
         end
         ST_RUN: begin
            // Redirect overrides any fetch or pop in the same cycle.
            if (redirect_valid) begin
               count_d = 2'd0;
               if (misaligned) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
               end else begin
                  pc_d = redirect_target;
               end
            end else if (fetch_req && out_of_range) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               count_d = 2'd0;
            end else begin
               push = fetch_req;
               if (push) pc_d = pc_q + 32'd4;
               if (pop) head_d = ~head_q;
               case ({push, pop})
                  2'b10:   count_d = count_q + 2'd1;
                  2'b01:   count_d = count_q - 2'd1;
                  default: count_d = count_q;
               endcase
            end
         end
         default: begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         pc_q    <= RESET_PC;
         count_q <= 2'd0;
         head_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         head_q  <= head_d;
         fault_q <= fault_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_pc_q  <= '{default: '0};
         buf_ins_q <= '{default: '0};
      end else if (push) begin
         buf_pc_q[tail]  <= pc_q;
         buf_ins_q[tail] <= imem_instr;
      end
   end

   assign imem_addr = pc_q;
   assign out_valid = (state_q == ST_RUN) && (count_q != 2'd0);
   assign out_pc    = buf_pc_q[head_q];
   assign out_instr = buf_ins_q[head_q];
   assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: per-cycle vector table plus hand-written
// sequences for fault persistence, end-of-memory and asynchronous reset.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        fault;

   int checks = 0;
   int errors = 0;

   fetch_pc_unit #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_instr       (out_instr),
      .fault           (fault)
   );

   always #5 clk = ~clk;

   // Words 0..3 hold NOPs; higher words carry their address for traceability.
   function automatic logic [31:0] imem_fn(input logic [31:0] a);
      if (a[31:2] < 30'd4) return 32'h0000_0013;
      return {a[15:0], 16'h0013};
   endfunction

   assign imem_instr = imem_fn(imem_addr);

   typedef struct {
      bit          rst;
      logic        rv;
      logic [31:0] tgt;
      logic        rdy;
      logic        e_valid;
      logic [31:0] e_pc;
      logic        e_fault;
      logic [31:0] e_addr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rst, input logic rv, input logic [31:0] tgt, input logic rdy,
                      input logic ev, input logic [31:0] epc, input logic ef, input logic [31:0] ea);
      vec_t v;
      v.rst = rst; v.rv = rv; v.tgt = tgt; v.rdy = rdy;
      v.e_valid = ev; v.e_pc = epc; v.e_fault = ef; v.e_addr = ea;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int          n;
      int          seq_err;
      logic [31:0] exp_next;
      logic [31:0] last_pc;

      // A: streaming from reset with decode always ready
      add(1, 0, 0,     1, 0, 0,     0, 32'h00);
      add(0, 0, 0,     1, 1, 32'h0, 0, 32'h04);
      add(0, 0, 0,     1, 1, 32'h4, 0, 32'h08);
      add(0, 0, 0,     1, 1, 32'h8, 0, 32'h0C);
      add(0, 0, 0,     1, 1, 32'hC, 0, 32'h10);
      // B: backpressure saturates the buffer, then drains in order
      add(1, 0, 0,     0, 0, 0,     0, 32'h00);
      add(0, 0, 0,     0, 1, 32'h0, 0, 32'h04);
      add(0, 0, 0,     0, 1, 32'h0, 0, 32'h08);
      add(0, 0, 0,     0, 1, 32'h0, 0, 32'h08);
      add(0, 0, 0,     0, 1, 32'h0, 0, 32'h08);
      add(0, 0, 0,     0, 1, 32'h0, 0, 32'h08);
      add(0, 0, 0,     1, 1, 32'h4, 0, 32'h0C);
      add(0, 0, 0,     1, 1, 32'h8, 0, 32'h10);
      add(0, 0, 0,     1, 1, 32'hC, 0, 32'h14);
      // C: redirect with a full buffer flushes it
      add(1, 0, 0,     0, 0, 0,      0, 32'h00);
      add(0, 0, 0,     0, 1, 32'h0,  0, 32'h04);
      add(0, 0, 0,     0, 1, 32'h0,  0, 32'h08);
      add(0, 1, 32'h40, 1, 0, 0,     0, 32'h40);
      add(0, 0, 0,     1, 1, 32'h40, 0, 32'h44);
      add(0, 0, 0,     1, 1, 32'h44, 0, 32'h48);
      // D: misaligned redirect faults; later redirect ignored
      add(1, 0, 0,      1, 0, 0,     0, 32'h00);
      add(0, 0, 0,      1, 1, 32'h0, 0, 32'h04);
      add(0, 1, 32'h42, 1, 0, 0,     1, 32'h04);
      add(0, 1, 32'h40, 1, 0, 0,     1, 32'h04);
      // E: aligned out-of-range redirect loads, faults on the next fetch
      add(1, 0, 0,       1, 0, 0, 0, 32'h00);
      add(0, 1, 32'h100, 1, 0, 0, 0, 32'h100);
      add(0, 0, 0,       1, 0, 0, 1, 32'h100);
      // F: redirect during INIT is taken
      add(1, 1, 32'h20, 1, 0, 0,      0, 32'h20);
      add(0, 0, 0,      1, 1, 32'h20, 0, 32'h24);

      rst_n = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = '0;
      out_ready = 1'b0;
      #12;
      chk("reset out_valid", 32'(out_valid), 0);
      chk("reset out_pc", out_pc, 0);
      chk("reset out_instr", out_instr, 0);
      chk("reset fault", 32'(fault), 0);
      chk("reset imem_addr", imem_addr, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         redirect_valid  = vecs[i].rv;
         redirect_target = vecs[i].tgt;
         out_ready       = vecs[i].rdy;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
         chk($sformatf("v%0d fault", i), 32'(fault), 32'(vecs[i].e_fault));
         chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
         if (vecs[i].e_valid) begin
            chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].e_pc);
            chk($sformatf("v%0d out_instr", i), out_instr, imem_fn(vecs[i].e_pc));
         end
      end

      // Fault is sticky for 20 cycles, then cleared asynchronously by reset
      do_reset();
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_target = 32'h42;
      @(negedge clk);
      redirect_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         chk($sformatf("sticky fault c%0d", c), {31'd0, fault, 1'b0} | 32'(out_valid), 32'h2);
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("async clr fault", 32'(fault), 0);
      chk("async clr addr", imem_addr, 0);

      // Sequential fetch runs off the end of a 32-word memory
      do_reset();
      out_ready = 1'b1;
      n = 0;
      seq_err = 0;
      exp_next = 32'h0;
      last_pc = 32'hFFFF_FFFF;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (fault) break;
         if (out_valid) begin
            if (out_pc !== exp_next) seq_err++;
            last_pc = out_pc;
            exp_next = exp_next + 32'd4;
            n++;
         end
      end
      chk("eom fault", 32'(fault), 1);
      chk("eom out_valid", 32'(out_valid), 0);
      chk("eom delivered", 32'(n), 32);
      chk("eom order errors", 32'(seq_err), 0);
      chk("eom last pc", last_pc, 32'h7C);

      // Asynchronous reset between edges while the head is valid
      do_reset();
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre-reset out_valid", 32'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid reset out_valid", 32'(out_valid), 0);
      chk("mid reset fault", 32'(fault), 0);
      chk("mid reset imem_addr", imem_addr, 0);
      chk("mid reset out_pc", out_pc, 0);
      #10 rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
